// File: rtl/reg_file_param_if.sv
// Register-file access bundle: write port, scoreboard issue port and NREAD read ports.
// Signal names match the original flat port list of reg_file_param.
interface reg_file_param_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned NREAD = 2,
  localparam int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
);
  logic                   wEn;
  logic [AW-1:0]          rd;
  logic [XLEN-1:0]        data;
  logic [NREAD*AW-1:0]    rs;
  logic [NREAD*XLEN-1:0]  out;
  logic                   issueEn;
  logic [AW-1:0]          issueRd;
  logic [NREAD-1:0]       busy;

  modport master (
    output wEn, rd, data, rs, issueEn, issueRd,
    input  out, busy
  );

  modport slave (
    input  wEn, rd, data, rs, issueEn, issueRd,
    output out, busy
  );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file with x0 hardwired to zero and a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN adds combinational write-through on the read ports.
module reg_file_param #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned NREAD = 2,
  localparam int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input logic               clk,
  input logic               reset,
  reg_file_param_if.slave   bus
);

  localparam logic [AW:0] NREG_W = NREG[AW:0];

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic            wr_ok;
  logic            iss_ok;

  function automatic logic idx_valid(input logic [AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < NREG_W);
  endfunction

  assign wr_ok  = bus.wEn     && idx_valid(bus.rd);
  assign iss_ok = bus.issueEn && idx_valid(bus.issueRd);

  // Issue is applied after the write clear so a same-index collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        regs[bus.rd]   <= bus.data;
        busy_q[bus.rd] <= 1'b0;
      end
      if (iss_ok) begin
        busy_q[bus.issueRd] <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] idx;
    bus.out  = '0;
    bus.busy = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      idx = bus.rs[i*AW +: AW];
      if (idx_valid(idx)) begin
        bus.out[i*XLEN +: XLEN] = regs[idx];
        bus.busy[i]             = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
        // Write-through is suppressed under reset so outputs stay zero while reset is held.
        if (!reset && wr_ok && (idx == bus.rd)) begin
          bus.out[i*XLEN +: XLEN] = bus.data;
        end
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed vector table plus randomized traffic against an array model.
module tb_reg_file_param;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 24;
  localparam int unsigned NREAD = 3;
  localparam int unsigned AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_param_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) bus ();

  reg_file_param #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] mregs [NREG];
  bit              mbusy [NREG];
  bit              mvalid = 1'b0;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          wen;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          iss;
    logic [4:0]  ird;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [31:0] o0;
    logic [31:0] o0b;
    logic [31:0] o1;
    logic [31:0] o1b;
    bit          b0;
    bit          b1;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(bit chk, bit rst, bit wen, int rd, int data, bit iss, int ird,
                            int rs0, int rs1, int o0, int o0b, int o1, int o1b, bit b0, bit b1);
    vec_t e;
    e.chk = chk; e.rst = rst; e.wen = wen; e.rd = rd[4:0]; e.data = data;
    e.iss = iss; e.ird = ird[4:0]; e.rs0 = rs0[4:0]; e.rs1 = rs1[4:0];
    e.o0 = o0; e.o0b = o0b; e.o1 = o1; e.o1b = o1b; e.b0 = b0; e.b1 = b1;
    tbl.push_back(e);
  endfunction

  function automatic bit in_rng(int idx);
    return (idx > 0) && (idx < int'(NREG));
  endfunction

  function automatic logic [XLEN-1:0] exp_out(int idx);
    if (!in_rng(idx)) return '0;
    if (BYP && !reset && bus.wEn && (int'(bus.rd) == idx)) return bus.data;
    return mregs[idx];
  endfunction

  function automatic bit exp_busy(int idx);
    return in_rng(idx) ? mbusy[idx] : 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit wen, input logic [4:0] rd, input logic [31:0] data,
                       input bit iss, input logic [4:0] ird,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2);
    reset       = rst;
    bus.wEn     = wen;
    bus.rd      = rd;
    bus.data    = data;
    bus.issueEn = iss;
    bus.issueRd = ird;
    bus.rs      = {rs2, rs1, rs0};
  endtask

  task automatic model_check();
    int idx;
    if (!mvalid) return;
    for (int i = 0; i < int'(NREAD); i++) begin
      idx = int'(bus.rs[i*AW +: AW]);
      check($sformatf("model_out%0d_x%0d", i, idx), bus.out[i*XLEN +: XLEN], exp_out(idx));
      check($sformatf("model_busy%0d_x%0d", i, idx), {31'b0, bus.busy[i]}, {31'b0, exp_busy(idx)});
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mregs[i] = '0;
        mbusy[i] = 1'b0;
      end
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (bus.wEn && in_rng(int'(bus.rd))) begin
        mregs[bus.rd] = bus.data;
        mbusy[bus.rd] = 1'b0;
      end
      if (bus.issueEn && in_rng(int'(bus.issueRd))) mbusy[bus.issueRd] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    //  chk rst wen rd  data         iss ird  rs0 rs1  o0    o0b   o1    o1b   b0 b1
    v(0, 1, 0, 0,  0,            0, 0,   0,  0,   0,    0,    0,    0,    0, 0);
    v(1, 0, 1, 1,  2,            0, 0,   0,  0,   0,    0,    0,    0,    0, 0);
    v(1, 0, 1, 2,  4,            0, 0,   1,  1,   2,    2,    2,    2,    0, 0);
    v(1, 0, 1, 3,  8,            0, 0,   2,  1,   4,    4,    2,    2,    0, 0);
    v(1, 0, 0, 0,  0,            0, 0,   2,  1,   4,    4,    2,    2,    0, 0);
    v(1, 0, 1, 0,  'hDEADBEEF,   0, 0,   3,  0,   8,    8,    0,    0,    0, 0);
    v(1, 0, 0, 0,  0,            1, 0,   0,  0,   0,    0,    0,    0,    0, 0);
    v(1, 0, 0, 0,  0,            1, 5,   0,  5,   0,    0,    0,    0,    0, 0);
    v(1, 0, 0, 0,  0,            0, 0,   0,  5,   0,    0,    0,    0,    0, 1);
    v(1, 0, 0, 0,  0,            0, 0,   0,  5,   0,    0,    0,    0,    0, 1);
    v(1, 0, 0, 0,  0,            0, 0,   0,  5,   0,    0,    0,    0,    0, 1);
    v(1, 0, 1, 5,  32,           0, 0,   5,  5,   0,    32,   0,    32,   1, 1);
    v(1, 0, 0, 0,  0,            0, 0,   5,  0,   32,   32,   0,    0,    0, 0);
    v(1, 0, 0, 0,  0,            1, 6,   6,  5,   0,    0,    32,   32,   0, 0);
    v(1, 0, 1, 6,  7,            1, 6,   6,  5,   0,    7,    32,   32,   1, 0);
    v(1, 0, 0, 0,  0,            0, 0,   6,  5,   7,    7,    32,   32,   1, 0);
    v(1, 0, 1, 6,  9,            0, 0,   6,  5,   7,    9,    32,   32,   1, 0);
    v(1, 0, 0, 0,  0,            0, 0,   6,  5,   9,    9,    32,   32,   0, 0);
    v(1, 0, 1, 7,  1,            0, 0,   7,  6,   0,    1,    9,    9,    0, 0);
    v(1, 0, 1, 7,  'h55,         0, 0,   7,  6,   1,    'h55, 9,    9,    0, 0);
    v(1, 0, 0, 0,  0,            0, 0,   7,  6,   'h55, 'h55, 9,    9,    0, 0);
    v(1, 0, 0, 0,  0,            1, 3,   3,  7,   8,    8,    'h55, 'h55, 0, 0);
    v(1, 1, 1, 3,  99,           1, 3,   3,  7,   8,    8,    'h55, 'h55, 1, 0);
    v(1, 0, 0, 0,  0,            0, 0,   3,  7,   0,    0,    0,    0,    0, 0);
    v(1, 0, 1, 25, 5,            1, 26,  25, 26,  0,    0,    0,    0,    0, 0);
    v(1, 0, 0, 0,  0,            0, 0,   25, 26,  0,    0,    0,    0,    0, 0);
    v(1, 0, 1, 23, 'hA5,         1, 23,  23, 0,   0,    'hA5, 0,    0,    0, 0);
    v(1, 0, 0, 0,  0,            0, 0,   23, 0,   'hA5, 'hA5, 0,    0,    1, 0);

    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].wen, tbl[n].rd, tbl[n].data, tbl[n].iss, tbl[n].ird,
            tbl[n].rs0, tbl[n].rs1, tbl[n].rs0);
      #1;
      if (tbl[n].chk) begin
        check($sformatf("vec%0d_out0", n), bus.out[0 +: XLEN], BYP ? tbl[n].o0b : tbl[n].o0);
        check($sformatf("vec%0d_out1", n), bus.out[XLEN +: XLEN], BYP ? tbl[n].o1b : tbl[n].o1);
        check($sformatf("vec%0d_out2", n), bus.out[2*XLEN +: XLEN], BYP ? tbl[n].o0b : tbl[n].o0);
        check($sformatf("vec%0d_busy", n), {29'b0, bus.busy},
              {29'b0, tbl[n].b0, tbl[n].b1, tbl[n].b0});
      end
      model_check();
      tick();
    end

    // Reset held over several cycles with write/issue traffic that must not take effect.
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b1, 5'(n + 1), $urandom, 1'b1, 5'(n + 1), 5'(n + 1), 5'(n + 2), 5'(n));
      #1;
      model_check();
      tick();
    end

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
            $urandom, $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1;
      model_check();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter XLEN, default 32: bit width of each register.
REQ-002 Parameter NREG, default 32: number of architectural registers; legal range 2..64.
REQ-003 Parameter NREAD, default 2: number of independent read ports; legal range 1..4.
REQ-004 Derived AW = clog2(NREG): width of every register index.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wEn  in  1  write enable for the write port.
REQ-008 rd  in  AW  write register index.
REQ-009 data  in  XLEN  write data.
REQ-010 rs  in  NREAD*AW  packed read indices; port i occupies bits [i*AW +: AW].
REQ-011 out  out  NREAD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
REQ-012 issueEn  in  1  scoreboard set strobe: marks issueRd as pending a write.
REQ-013 issueRd  in  AW  register index to mark busy.
REQ-014 busy  out  NREAD  busy[i] is the pending flag of register rs[i].

Function
REQ-015 Write: on a rising clk with wEn=1 and reset=0, register rd SHALL take data, with 1-cycle write latency.
REQ-016 Register 0 SHALL be hardwired to zero: writes to it are discarded, reads return 0, and its busy flag is never set.
REQ-017 Read: out port i SHALL be a combinational function of rs[i] and current state, with 0-cycle latency and no read enable.
REQ-018 Any index >= NREG (non-power-of-2 NREG): writes and issues ignored; reads return 0; busy reads 0.
REQ-019 Scoreboard: one busy bit per register; issueEn=1 sets bit issueRd at the clock edge.
REQ-020 A write (wEn=1) SHALL clear the busy bit of rd at the same edge as the data update.
REQ-021 Simultaneous issue and write to the same index SHALL leave the bit set (the new producer wins); the data update still occurs.
REQ-022 Simultaneous issue and write to different indices SHALL apply both.
REQ-023 busy[i] SHALL reflect registered state only; a same-cycle wEn never masks busy combinationally.
REQ-024 Multiple read ports addressing the same register SHALL return identical data and busy values.
REQ-025 Writes to a register not marked busy SHALL be legal and SHALL leave its busy bit at 0.

Reset
REQ-026 reset=1 at a rising clk SHALL clear all registers to 0 and all busy bits to 0.
REQ-027 reset SHALL dominate wEn and issueEn in the same cycle; neither takes effect.
REQ-028 While reset is held, out=0 and busy=0 on all ports from the first reset edge onward.
REQ-029 A reset asserted mid-sequence SHALL discard all pending busy state with no residual effect after deassertion.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN. When defined, a read whose rs[i] equals rd while wEn=1 (rd != 0, in range) SHALL return data combinationally (write-through).
REQ-031 Without REGFILE_BYPASS_EN, the same read SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-032 REGFILE_BYPASS_EN SHALL NOT alter busy behaviour or reset behaviour.

Verification
REQ-033 Reset then write: reset 1 cycle, then write 2->x1, 4->x2, 8->x3 on consecutive edges -> rs={x2,x1} reads {4,2}; x3 reads 8.
REQ-034 Zero register: write 0xDEADBEEF to x0 -> x0 reads 0 on all ports; issue x0 -> busy for x0 stays 0.
REQ-035 Scoreboard: issue x5, then 3 idle cycles, then write 32->x5 -> busy for x5 is 1 for cycles 1..4 and 0 after the write edge; x5 reads 32.
REQ-036 Collision: x6 busy, same edge wEn rd=x6 data=7 and issueEn issueRd=x6 -> x6 reads 7 and busy stays 1; a following write of 9 -> busy 0.
REQ-037 Bypass: x7=1, then wEn rd=x7 data=0x55 with rs[0]=x7 in the same cycle -> out0=0x55 with REGFILE_BYPASS_EN, 1 without; both 0x55 next cycle.
REQ-038 Reset priority: x3=8 and x3 busy, then reset=1 with wEn rd=x3 data=99 -> next cycle x3=0, busy=0; all ports read 0.
